// File: rtl/matmul_push_ctrl.sv
// matmul_push_ctrl
//   Sequences one matmul on the systolic array. On start it arms the warp
//   selector, then streams num_rows operand rows into the array. A row is
//   pushed on every cycle that the selector does not pause. It then drains the
//   array and pulses matmul_done, which also clears the selector's push mode.
//
//   Optional feature macro: PUSH_TIMEOUT_EN. When it is defined, a run of
//   TIMEOUT_CYCLES consecutive paused PUSH cycles aborts the run. The abort
//   goes through DONE and raises timeout_err together with matmul_done.
//
// Ports
//   clk            clock
//   reset          synchronous, active-high reset
//   start          begin a matmul; sampled only in IDLE
//   num_rows       rows to push; latched when start is accepted
//   push_warp      warp supplying the current row (from selector)
//   pause          selected warp not ready (from selector)
//   push_en        one-cycle pulse arming the selector
//   row_valid      row accepted this cycle
//   row_warp       push_warp when row_valid, else 0
//   row_idx        index of the current row
//   array_shift_en advance the systolic array this cycle
//   matmul_done    one-cycle completion pulse
//   busy           controller not idle
//   timeout_err    one-cycle abort pulse (0 without PUSH_TIMEOUT_EN)
//
// State  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for start
// ARM    | one cycle, push_en high, row index cleared
// PUSH   | one row per non-paused cycle until the last row is accepted
// DRAIN  | 2*ARRAY_DIM-1 cycles of array shifting, pause ignored
// DONE   | one cycle, matmul_done high (timeout_err too on abort)
module matmul_push_ctrl #(
    parameter int NUM_WARPS      = 4,
    parameter int ARRAY_DIM      = 4,
    parameter int ROWS_W         = 8,
    parameter int TIMEOUT_CYCLES = 64,
    localparam int WARP_W        = $clog2(NUM_WARPS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ROWS_W-1:0] num_rows,
    input  logic [WARP_W-1:0] push_warp,
    input  logic              pause,
    output logic              push_en,
    output logic              row_valid,
    output logic [WARP_W-1:0] row_warp,
    output logic [ROWS_W-1:0] row_idx,
    output logic              array_shift_en,
    output logic              matmul_done,
    output logic              busy,
    output logic              timeout_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_PUSH,
        S_DRAIN,
        S_DONE
    } state_t;

    // Drain counter is a down-counter loaded with the last index and
    // terminating at zero, giving exactly 2*ARRAY_DIM-1 drain cycles.
    localparam logic [ROWS_W-1:0] DRAIN_LAST = ROWS_W'(2 * ARRAY_DIM - 2);

    state_t            state_q, state_d;
    logic [ROWS_W-1:0] rows_q, rows_d;
    logic [ROWS_W-1:0] idx_q, idx_d;
    logic [ROWS_W-1:0] drain_q, drain_d;

`ifdef PUSH_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    // Pause budget counts down on each paused PUSH cycle; reaching zero on a
    // paused cycle means TIMEOUT_CYCLES consecutive pauses have occurred.
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            to_flag_q, to_flag_d;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            rows_q    <= '0;
            idx_q     <= '0;
            drain_q   <= '0;
`ifdef PUSH_TIMEOUT_EN
            to_cnt_q  <= '0;
            to_flag_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            rows_q    <= rows_d;
            idx_q     <= idx_d;
            drain_q   <= drain_d;
`ifdef PUSH_TIMEOUT_EN
            to_cnt_q  <= to_cnt_d;
            to_flag_q <= to_flag_d;
`endif
        end
    end

    always_comb begin
        state_d        = state_q;
        rows_d         = rows_q;
        idx_d          = idx_q;
        drain_d        = drain_q;
        push_en        = 1'b0;
        row_valid      = 1'b0;
        array_shift_en = 1'b0;
        matmul_done    = 1'b0;
`ifdef PUSH_TIMEOUT_EN
        to_cnt_d       = to_cnt_q;
        to_flag_d      = to_flag_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    rows_d  = num_rows;
                    state_d = (num_rows != '0) ? S_ARM : S_DONE;
                end
            end
            S_ARM: begin
                push_en = 1'b1;
                idx_d   = '0;
                state_d = S_PUSH;
`ifdef PUSH_TIMEOUT_EN
                to_cnt_d = TO_LAST;
`endif
            end
            S_PUSH: begin
                if (!pause) begin
                    row_valid      = 1'b1;
                    array_shift_en = 1'b1;
`ifdef PUSH_TIMEOUT_EN
                    to_cnt_d = TO_LAST;
`endif
                    // The index stops at the last row so it stays in range
                    // while it holds through DRAIN.
                    if (idx_q == rows_q - ROWS_W'(1)) begin
                        state_d = S_DRAIN;
                        drain_d = DRAIN_LAST;
                    end else begin
                        idx_d = idx_q + ROWS_W'(1);
                    end
                end
`ifdef PUSH_TIMEOUT_EN
                else if (to_cnt_q == '0) begin
                    state_d   = S_DONE;
                    to_flag_d = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_q - TO_W'(1);
                end
`endif
            end
            S_DRAIN: begin
                array_shift_en = 1'b1;
                if (drain_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    drain_d = drain_q - ROWS_W'(1);
                end
            end
            S_DONE: begin
                matmul_done = 1'b1;
                state_d     = S_IDLE;
`ifdef PUSH_TIMEOUT_EN
                to_flag_d   = 1'b0;
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy     = (state_q != S_IDLE);
    assign row_idx  = idx_q;
    assign row_warp = row_valid ? push_warp : '0;

`ifdef PUSH_TIMEOUT_EN
    assign timeout_err = (state_q == S_DONE) && to_flag_q;
`else
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_matmul_push_ctrl.sv
module tb_matmul_push_ctrl;

    localparam int ROWS_W   = 8;
    localparam int DIM      = 4;
    localparam int TO       = 8;
    localparam int DRAIN_N  = 2 * DIM - 1;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [ROWS_W-1:0] num_rows;
    logic [1:0]        push_warp;
    logic              pause;
    logic              push_en;
    logic              row_valid;
    logic [1:0]        row_warp;
    logic [ROWS_W-1:0] row_idx;
    logic              array_shift_en;
    logic              matmul_done;
    logic              busy;
    logic              timeout_err;

    int n_checks = 0;
    int n_fail   = 0;

    matmul_push_ctrl #(
        .NUM_WARPS(4), .ARRAY_DIM(DIM), .ROWS_W(ROWS_W), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .num_rows(num_rows),
        .push_warp(push_warp), .pause(pause), .push_en(push_en),
        .row_valid(row_valid), .row_warp(row_warp), .row_idx(row_idx),
        .array_shift_en(array_shift_en), .matmul_done(matmul_done),
        .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Expected outputs for one cycle; idx < 0 means row_idx is not checked.
    typedef struct {
        bit pe;
        bit rv;
        int idx;
        bit se;
        bit done;
        bit busy;
        bit terr;
        bit pz;
    } exp_t;

    function automatic exp_t blank();
        exp_t e;
        e.pe = 0; e.rv = 0; e.idx = -1; e.se = 0; e.done = 0;
        e.busy = 0; e.terr = 0; e.pz = 1'($urandom_range(1));
        return e;
    endfunction

    task automatic check_all_zero(input string tag);
        chk({tag, ".push_en"}, 32'(push_en), 0);
        chk({tag, ".row_valid"}, 32'(row_valid), 0);
        chk({tag, ".row_warp"}, 32'(row_warp), 0);
        chk({tag, ".row_idx"}, 32'(row_idx), 0);
        chk({tag, ".shift"}, 32'(array_shift_en), 0);
        chk({tag, ".done"}, 32'(matmul_done), 0);
        chk({tag, ".busy"}, 32'(busy), 0);
        chk({tag, ".terr"}, 32'(timeout_err), 0);
    endtask

    // Builds the expected timeline of a whole matmul from the row/pause rules,
    // then drives it cycle by cycle. pct<0 selects pauses from mask (bit k
    // applies to the k-th PUSH cycle), otherwise pauses are random with pct%.
    task automatic run(input string name, input int n, input int pct,
                       input logic [31:0] mask, input bit poke);
        exp_t tl[$];
        exp_t e;
        int sent, consec, k;
        bit timed_out, p;
        logic [1:0] w;
        string tag;

        tl = {};
        timed_out = 0;
        tl.push_back(blank());
        if (n != 0) begin
            e = blank(); e.pe = 1; e.busy = 1;
            tl.push_back(e);
            sent = 0; consec = 0; k = 0;
            while (sent < n && !timed_out) begin
                if (pct < 0) p = (k < 32) ? mask[k] : 1'b0;
                else         p = ($urandom_range(99) < pct);
                if (tl.size() > 600) p = 0;
                e = blank(); e.busy = 1; e.pz = p; e.idx = sent;
                if (p) begin
                    consec++;
                end else begin
                    e.rv = 1; e.se = 1; sent++; consec = 0;
                end
                tl.push_back(e);
                k++;
`ifdef PUSH_TIMEOUT_EN
                if (consec == TO) timed_out = 1;
`endif
            end
            if (!timed_out) begin
                for (int d = 0; d < DRAIN_N; d++) begin
                    e = blank(); e.busy = 1; e.se = 1;
                    tl.push_back(e);
                end
            end
        end
        e = blank(); e.busy = 1; e.done = 1; e.terr = timed_out;
        tl.push_back(e);
        tl.push_back(blank());

        foreach (tl[i]) begin
            @(posedge clk); #1;
            w = 2'($urandom_range(3));
            start = (i == 0) ? 1'b1
                  : (poke && i < tl.size() - 1) ? 1'($urandom_range(1)) : 1'b0;
            num_rows = (i == 0) ? ROWS_W'(n) : ROWS_W'($urandom_range(255));
            pause = tl[i].pz;
            push_warp = w;
            @(negedge clk);
            tag = $sformatf("%s.t%0d", name, i);
            chk({tag, ".push_en"}, 32'(push_en), 32'(tl[i].pe));
            chk({tag, ".row_valid"}, 32'(row_valid), 32'(tl[i].rv));
            chk({tag, ".row_warp"}, 32'(row_warp), tl[i].rv ? 32'(w) : 0);
            if (tl[i].idx >= 0) chk({tag, ".row_idx"}, 32'(row_idx), 32'(tl[i].idx));
            chk({tag, ".shift"}, 32'(array_shift_en), 32'(tl[i].se));
            chk({tag, ".done"}, 32'(matmul_done), 32'(tl[i].done));
            chk({tag, ".busy"}, 32'(busy), 32'(tl[i].busy));
            chk({tag, ".terr"}, 32'(timeout_err), 32'(tl[i].terr));
        end
        @(posedge clk); #1;
        start = 0;
    endtask

    task automatic reset_mid_push();
        // t0 start, t1 ARM, t2 row 0, t3 reset with row_idx=1, t4 all zero.
        @(posedge clk); #1; start = 1; num_rows = 3; pause = 0;
        @(posedge clk); #1; start = 0;
        @(posedge clk); #1;
        @(posedge clk); #1; reset = 1;
        @(negedge clk);
        chk("rst.row_idx_before", 32'(row_idx), 1);
        @(posedge clk); #1; reset = 0;
        @(negedge clk);
        check_all_zero("rst.after");
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            pause = 1'($urandom_range(1));
            @(negedge clk);
            chk($sformatf("rst.quiet%0d.done", i), 32'(matmul_done), 0);
            chk($sformatf("rst.quiet%0d.busy", i), 32'(busy), 0);
        end
    endtask

    initial begin
        reset = 1; start = 0; num_rows = 0; push_warp = 0; pause = 0;
        repeat (3) @(posedge clk);
        #1;
        start = 1; num_rows = 5;
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #1;
        reset = 0; start = 0;

        run("case1", 3, 0, 0, 0);
        run("case2", 3, -1, 32'b0110, 0);
        run("case3", 0, 0, 0, 0);
        run("case4", 5, 30, 0, 1);
        run("one_row", 1, 0, 0, 0);
        run("max_rows", 255, 0, 0, 0);
        reset_mid_push();
        run("case5", 3, 0, 0, 0);
`ifdef PUSH_TIMEOUT_EN
        run("timeout", 3, 100, 0, 0);
        run("to_edge", 2, -1, 32'h0000_00FE, 0);
        run("to_reset", 2, -1, 32'h0000_01FE, 0);
`endif
        for (int r = 0; r < 40; r++) begin
            run($sformatf("rnd%0d", r), $urandom_range(12), $urandom_range(50),
                0, 1'($urandom_range(1)));
        end

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
